// File: rtl/key_move_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_move_scheduler                                         |
// | Description : Turns held key codes from keyboard_driver into a queue of  |
// |               direction commands and releases one command per game step |
// |               on a periodic move strobe for rect_controller.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk         in   1  system clock (65 MHz domain)                       |
// |   rst         in   1  synchronous active-high reset                      |
// |   key_in      in   8  held key code: 01 up, 02 down, 04 left, 08 right   |
// |   game_run    in   1  high = game running, low = paused/idle             |
// |   speed_up    in   1  (KEY_MOVE_SCHEDULER_SPEEDUP_EN only) shorten period |
// |   dir         out  2  current direction: 00 up, 01 down, 10 left, 11 rt  |
// |   move_tick   out  1  one-cycle strobe per game step                     |
// |   queue_count out  3  occupied queue entries after the current edge      |
// |   key_drop    out  1  pulse when a valid command hits a full queue       |
// +--------------------------------------------------------------------------+
// | Optional feature macro: KEY_MOVE_SCHEDULER_SPEEDUP_EN                     |
// |   Adds speed_up input and SPEED_STEP / MIN_PERIOD parameters. Each high  |
// |   speed_up cycle shortens the step period by SPEED_STEP down to          |
// |   MIN_PERIOD; the new period applies at the next counter reload.         |
// +--------------------------------------------------------------------------+
module key_move_scheduler #(
  parameter int MOVE_PERIOD = 6500000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 24
`ifdef KEY_MOVE_SCHEDULER_SPEEDUP_EN
  ,
  parameter int SPEED_STEP  = 325000,
  parameter int MIN_PERIOD  = 1300000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       game_run,
`ifdef KEY_MOVE_SCHEDULER_SPEEDUP_EN
  input  logic       speed_up,
`endif
  output logic [1:0] dir,
  output logic       move_tick,
  output logic [2:0] queue_count,
  output logic       key_drop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTQ_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  c_RELOAD = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [CNTQ_W-1:0] c_DEPTH  = CNTQ_W'(FIFO_DEPTH);

  // Direction queue state
  logic [1:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNTQ_W-1:0] r_count;

  logic [7:0]        r_key_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_dir;
  logic              r_move_tick;
  logic              r_key_drop;

  logic [CNT_W-1:0]  w_reload_val;
  logic              w_key_valid;
  logic [1:0]        w_key_dir;
  logic              w_event;
  logic [PTR_W-1:0]  w_tail_idx;
  logic [1:0]        w_ref;
  logic              w_legal;
  logic              w_full;
  logic              w_cnt_zero;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

`ifdef KEY_MOVE_SCHEDULER_SPEEDUP_EN
  localparam logic [CNT_W-1:0] c_PERIOD = CNT_W'(MOVE_PERIOD);
  localparam logic [CNT_W-1:0] c_STEP   = CNT_W'(SPEED_STEP);
  localparam logic [CNT_W-1:0] c_MIN    = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] r_period;

  // Active period survives pause; only reset restores the base rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= c_PERIOD;
    end else if (speed_up && (r_period > c_MIN)) begin
      if (r_period > (c_MIN + c_STEP)) begin
        r_period <= r_period - c_STEP;
      end else begin
        r_period <= c_MIN;
      end
    end
  end

  assign w_reload_val = r_period - CNT_W'(1);
`else
  assign w_reload_val = c_RELOAD;
`endif

  // Key decode: only the four one-hot codes are commands.
  always_comb begin
    w_key_valid = 1'b1;
    w_key_dir   = 2'b00;
    case (key_in)
      8'h01:   w_key_dir = 2'b00;
      8'h02:   w_key_dir = 2'b01;
      8'h04:   w_key_dir = 2'b10;
      8'h08:   w_key_dir = 2'b11;
      default: w_key_valid = 1'b0;
    endcase
  end

  // Edge detect on the held code so a held key yields a single event.
  assign w_event = w_key_valid && (key_in != r_key_prev);

  // Newest queued direction is the reference; fall back to the live one.
  assign w_tail_idx = r_wr_ptr - PTR_W'(1);
  assign w_ref      = (r_count != '0) ? r_fifo[w_tail_idx] : r_dir;

  // Reversal check relies on the encoding: opposite directions differ in bit 0.
  assign w_legal    = (w_key_dir != w_ref) && (w_key_dir != (w_ref ^ 2'b01));
  assign w_full     = (r_count == c_DEPTH);
  assign w_cnt_zero = (r_cnt == '0);

  // Fullness and occupancy are judged on pre-edge values, so a pop on the
  // same edge neither frees a slot for nor pops the incoming entry.
  assign w_pop  = game_run && w_cnt_zero && (r_count != '0);
  assign w_push = game_run && w_event && w_legal && !w_full;
  assign w_drop = game_run && w_event && w_legal && w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_prev  <= 8'h00;
      r_cnt       <= c_RELOAD;
      r_dir       <= 2'b11;
      r_move_tick <= 1'b0;
      r_key_drop  <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_key_prev <= key_in;
      if (!game_run) begin
        // Paused: flush queue, hold the counter at reload, hold dir.
        r_cnt       <= w_reload_val;
        r_move_tick <= 1'b0;
        r_key_drop  <= 1'b0;
        r_count     <= '0;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
      end else begin
        r_cnt       <= w_cnt_zero ? w_reload_val : (r_cnt - CNT_W'(1));
        r_move_tick <= w_cnt_zero;
        r_key_drop  <= w_drop;
        if (w_pop) begin
          r_dir    <= r_fifo[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNTQ_W'(1);
          2'b01:   r_count <= r_count - CNTQ_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_key_dir;
    end
  end

  assign dir         = r_dir;
  assign move_tick   = r_move_tick;
  assign queue_count = 3'(r_count);
  assign key_drop    = r_key_drop;

endmodule
`default_nettype wire

// File: tb/tb_key_move_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_move_scheduler                                      |
// | Description : Directed self-checking bench for key_move_scheduler with   |
// |               MOVE_PERIOD=8, FIFO_DEPTH=4.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_key_move_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic       game_run;
  logic [1:0] dir;
  logic       move_tick;
  logic [2:0] queue_count;
  logic       key_drop;

  int n_checks = 0;
  int n_errors = 0;

  key_move_scheduler #(
    .MOVE_PERIOD(8),
    .FIFO_DEPTH (4),
    .CNT_W      (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .game_run   (game_run),
    .dir        (dir),
    .move_tick  (move_tick),
    .queue_count(queue_count),
    .key_drop   (key_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until move_tick is seen, bounded.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!move_tick && n < 20);
    check_val("tick_seen", {31'd0, move_tick}, 32'd1);
  endtask

  task automatic check_state(input string tag, input logic [1:0] e_dir, input logic [2:0] e_cnt,
                             input logic e_tick, input logic e_drop);
    check_val({tag, "_dir"},  {30'd0, dir},         {30'd0, e_dir});
    check_val({tag, "_cnt"},  {29'd0, queue_count}, {29'd0, e_cnt});
    check_val({tag, "_tick"}, {31'd0, move_tick},   {31'd0, e_tick});
    check_val({tag, "_drop"}, {31'd0, key_drop},    {31'd0, e_drop});
  endtask

  initial begin
    rst      = 1'b1;
    key_in   = 8'h00;
    game_run = 1'b0;
    step();
    step();
    check_state("reset", 2'b11, 3'd0, 1'b0, 1'b0);

    // Free-running ticks with no keys: first pulse after 8 edges, spacing 8.
    rst      = 1'b0;
    game_run = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_val("period_tick", {31'd0, move_tick}, {31'd0, (i == 8 || i == 16)});
      check_val("period_dir", {30'd0, dir}, 32'd3);
    end

    // Held up key: one enqueue, popped at the next tick, no re-trigger.
    key_in = 8'h01;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) check_state("hold_q", 2'b11, 3'd1, 1'b0, 1'b0);
      if (i == 8) check_state("hold_pop", 2'b00, 3'd0, 1'b1, 1'b0);
      if (i > 8) check_val("hold_noev", {29'd0, queue_count}, 32'd0);
    end
    key_in = 8'h00;

    // Reversal rejected, then up/left chain queued.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("rst2", 2'b11, 3'd0, 1'b0, 1'b0);
    key_in = 8'h04; step();
    check_state("rev_left", 2'b11, 3'd0, 1'b0, 1'b0);
    key_in = 8'h00; step();
    key_in = 8'h01; step();
    check_val("chain_up", {29'd0, queue_count}, 32'd1);
    key_in = 8'h00; step();
    key_in = 8'h04; step();
    check_val("chain_left", {29'd0, queue_count}, 32'd2);
    key_in = 8'h00;
    wait_tick();
    check_state("chain_t1", 2'b00, 3'd1, 1'b1, 1'b0);
    wait_tick();
    check_state("chain_t2", 2'b10, 3'd0, 1'b1, 1'b0);

    // Five legal events between ticks: fifth dropped; then full+pop edge.
    key_in = 8'h01; step();
    check_val("burst1", {29'd0, queue_count}, 32'd1);
    key_in = 8'h04; step();
    key_in = 8'h02; step();
    key_in = 8'h08; step();
    check_state("burst4", 2'b10, 3'd4, 1'b0, 1'b0);
    key_in = 8'h01; step();
    check_state("burst5", 2'b10, 3'd4, 1'b0, 1'b1);
    step();
    check_state("drop_end", 2'b10, 3'd4, 1'b0, 1'b0);
    key_in = 8'h00; step();
    check_state("pre_tick", 2'b10, 3'd4, 1'b0, 1'b0);
    key_in = 8'h02; step();
    check_state("full_pop", 2'b00, 3'd3, 1'b1, 1'b1);

    // Pause with three queued: flush, no ticks, no drops, dir held.
    key_in   = 8'h00;
    game_run = 1'b0;
    step();
    check_state("pause", 2'b00, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      key_in = (i % 2 == 1) ? 8'h08 : 8'h00;
      step();
      check_state("paused", 2'b00, 3'd0, 1'b0, 1'b0);
    end
    key_in   = 8'h00;
    game_run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_val("resume_tick", {31'd0, move_tick}, {31'd0, (i == 8)});
    end
    check_val("resume_dir", {30'd0, dir}, 32'd0);

    // Event on the zero-count edge with one entry queued.
    key_in = 8'h04; step();
    check_val("zc_q", {29'd0, queue_count}, 32'd1);
    key_in = 8'h00;
    for (int i = 2; i <= 7; i++) step();
    check_state("zc_pre", 2'b00, 3'd1, 1'b0, 1'b0);
    key_in = 8'h01; step();
    check_state("zc_edge", 2'b10, 3'd1, 1'b1, 1'b0);
    key_in = 8'h00;
    wait_tick();
    check_state("zc_next", 2'b00, 3'd0, 1'b1, 1'b0);

    // Three queued, then reset instead of pause.
    key_in = 8'h04; step();
    key_in = 8'h02; step();
    key_in = 8'h08; step();
    check_val("rst_q3", {29'd0, queue_count}, 32'd3);
    key_in = 8'h00;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    check_state("rst_mid", 2'b11, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_val("rst_reload_tick", {31'd0, move_tick}, {31'd0, (i == 8)});
    end
    check_state("rst_after", 2'b11, 3'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
